// File: rtl/ebus_pkg.sv
// ebus_pkg: shared definitions for the EBUS cycle sequencer.
// State encoding, EBUS function codes, the 36-bit word width and a parity helper.
package ebus_pkg;

   // EBOX word width
   localparam int unsigned WORD_W = 36;
   localparam int unsigned CS_W   = 7;
   localparam int unsigned F_W    = 3;

   // EBUS function codes
   localparam logic [0:F_W-1] F_CONO     = 3'd0;
   localparam logic [0:F_W-1] F_CONI     = 3'd1;
   localparam logic [0:F_W-1] F_DATAO    = 3'd2;
   localparam logic [0:F_W-1] F_DATAI    = 3'd3;
   localparam logic [0:F_W-1] F_PIserved = 3'd4;

   // Sequencer states
   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StWaitd,
      StDemand,
      StHold,
      StDone
   } ebus_state_e;

   // Device drives odd parity: data bits plus parity bit must XOR to 1
   function automatic logic odd_parity_ok(input logic [0:WORD_W-1] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ebus_timer.sv
// ebus_timer: loadable down-counter with a zero flag.
// Load has priority over decrement; decrement saturates at zero.
module ebus_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] count_q;

   // Counter register: load, else decrement while non-zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/ebus_xfer.sv
// ebus_xfer: EBUS cycle sequencer for the EBOX I/O path.
// Runs CS/F setup, DEMAND/XFER handshake and DEMAND timeout for
// DATAI/DATAO/CONI/CONO transfers. Write data comes from edp; read data is
// captured into EBUS for edp.
// Optional feature: define EBUS_PARITY_EN to check odd parity on read capture.
module ebus_xfer
   import ebus_pkg::*;
#(
   parameter int unsigned SETUP_CYC   = 2,
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter int unsigned CNT_W       = 8
) (
   input  logic          eboxClk,
   input  logic          eboxReset_n,
   input  logic          CON_ebusReq,
   input  logic          CON_ebusWrite,
   input  logic [0:6]    CON_ebusCS,
   input  logic [0:2]    CON_ebusF,
   input  logic [0:35]   EDP_EBUS,
   input  logic          EDPdrivingEBUS,
   input  logic          EBUS_xfer,
   input  logic [0:35]   EBUS_dataIn,
   input  logic          EBUS_parityIn,
   output logic [0:6]    EBUS_cs,
   output logic [0:2]    EBUS_f,
   output logic          EBUS_demand,
   output logic [0:35]   EBUS_dataOut,
   output logic          EBUS_driveEn,
   output logic [0:35]   EBUS,
   output logic          ebusBusy,
   output logic          ebusDone,
   output logic          ebusTimeout,
   output logic          ebusParityErr
);

   localparam logic [CNT_W-1:0] SETUP_LOAD   = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYC - 1);

   ebus_state_e state_q, state_d;

   logic [0:CS_W-1]   cs_q;
   logic [0:F_W-1]    f_q;
   logic              dir_q;        // 1 = EBOX drives data
   logic [0:WORD_W-1] data_out_q;
   logic [0:WORD_W-1] ebus_q;
   logic              demand_q;
   logic              drive_en_q;
   logic              timeout_q;

   logic              tmr_load;
   logic [CNT_W-1:0]  tmr_val;
   logic              tmr_dec;
   logic              tmr_zero;

   logic              start;
   logic              read_capture;

   assign start        = (state_q == StIdle) && CON_ebusReq;
   assign read_capture = (state_q == StDemand) && EBUS_xfer && !dir_q;

   ebus_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (eboxClk),
      .rst_n    (eboxReset_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   // State register
   always_ff @(posedge eboxClk or negedge eboxReset_n) begin
      if (!eboxReset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (CON_ebusReq) begin
               state_d = (CON_ebusWrite && !EDPdrivingEBUS) ? StWaitd : StSetup;
            end
         end
         StWaitd: begin
            if (EDPdrivingEBUS) state_d = StSetup;
         end
         StSetup: begin
            if (tmr_zero) state_d = StDemand;
         end
         StDemand: begin
            // XFER wins over a counter reaching zero on the same edge
            if (EBUS_xfer)     state_d = StHold;
            else if (tmr_zero) state_d = StIdle;
         end
         StHold: begin
            if (!EBUS_xfer) state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Status outputs decoded from the current state
   always_comb begin
      ebusBusy = (state_q != StIdle);
      ebusDone = (state_q == StDone);
   end

   // Timer control: one counter serves both the SETUP and DEMAND windows
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = SETUP_LOAD;
      tmr_dec  = 1'b0;
      unique case (state_q)
         StIdle: begin
            tmr_load = CON_ebusReq;
            tmr_val  = SETUP_LOAD;
         end
         StSetup: begin
            tmr_load = tmr_zero;
            tmr_val  = TIMEOUT_LOAD;
            tmr_dec  = !tmr_zero;
         end
         StDemand: begin
            tmr_dec = !EBUS_xfer;
         end
         default: begin
            tmr_load = 1'b0;
         end
      endcase
   end

   // Bus datapath: CS/F/direction latch, write data, read capture, flags
   always_ff @(posedge eboxClk or negedge eboxReset_n) begin
      if (!eboxReset_n) begin
         cs_q       <= '0;
         f_q        <= '0;
         dir_q      <= 1'b0;
         data_out_q <= '0;
         ebus_q     <= '0;
         demand_q   <= 1'b0;
         drive_en_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         // Demand covers DEMAND and HOLD; registered off the next state
         demand_q <= (state_d == StDemand) || (state_d == StHold);

         if (start) begin
            cs_q      <= CON_ebusCS;
            f_q       <= CON_ebusF;
            dir_q     <= CON_ebusWrite;
            timeout_q <= 1'b0;
            if (CON_ebusWrite && EDPdrivingEBUS) begin
               data_out_q <= EDP_EBUS;
               drive_en_q <= 1'b1;
            end
         end

         if ((state_q == StWaitd) && EDPdrivingEBUS) begin
            data_out_q <= EDP_EBUS;
            drive_en_q <= 1'b1;
         end

         if (read_capture) begin
            ebus_q <= EBUS_dataIn;
         end

         if ((state_q == StDemand) && !EBUS_xfer && tmr_zero) begin
            timeout_q  <= 1'b1;
            drive_en_q <= 1'b0;
         end

         if ((state_q == StHold) && !EBUS_xfer) begin
            drive_en_q <= 1'b0;
         end

         if (state_q == StDone) begin
            cs_q <= '0;
            f_q  <= '0;
         end
      end
   end

`ifdef EBUS_PARITY_EN
   logic parity_err_q;

   // Sticky parity error, cleared at the start of each cycle
   always_ff @(posedge eboxClk or negedge eboxReset_n) begin
      if (!eboxReset_n) begin
         parity_err_q <= 1'b0;
      end else if (start) begin
         parity_err_q <= 1'b0;
      end else if (read_capture && !odd_parity_ok(EBUS_dataIn, EBUS_parityIn)) begin
         parity_err_q <= 1'b1;
      end
   end

   assign ebusParityErr = parity_err_q;
`else
   logic unused_parity;

   assign unused_parity = EBUS_parityIn;
   assign ebusParityErr = 1'b0;
`endif

   assign EBUS_cs      = cs_q;
   assign EBUS_f       = f_q;
   assign EBUS_demand  = demand_q;
   assign EBUS_dataOut = data_out_q;
   assign EBUS_driveEn = drive_en_q;
   assign EBUS         = ebus_q;
   assign ebusTimeout  = timeout_q;

endmodule

// File: tb/tb_ebus_xfer.sv
// tb_ebus_xfer: directed self-checking bench for ebus_xfer (default parameters).
// Define EBUS_PARITY_EN to exercise the parity-check build.
module tb_ebus_xfer;
   import ebus_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        req;
   logic        write;
   logic [0:6]  cs;
   logic [0:2]  f;
   logic [0:35] edp_ebus;
   logic        edp_driving;
   logic        xfer;
   logic [0:35] data_in;
   logic        parity_in;
   logic [0:6]  bus_cs;
   logic [0:2]  bus_f;
   logic        demand;
   logic [0:35] data_out;
   logic        drive_en;
   logic [0:35] ebus;
   logic        busy;
   logic        done;
   logic        timeout;
   logic        parity_err;

   int n_vec;
   int n_err;

   ebus_xfer dut (
      .eboxClk        (clk),
      .eboxReset_n    (rst_n),
      .CON_ebusReq    (req),
      .CON_ebusWrite  (write),
      .CON_ebusCS     (cs),
      .CON_ebusF      (f),
      .EDP_EBUS       (edp_ebus),
      .EDPdrivingEBUS (edp_driving),
      .EBUS_xfer      (xfer),
      .EBUS_dataIn    (data_in),
      .EBUS_parityIn  (parity_in),
      .EBUS_cs        (bus_cs),
      .EBUS_f         (bus_f),
      .EBUS_demand    (demand),
      .EBUS_dataOut   (data_out),
      .EBUS_driveEn   (drive_en),
      .EBUS           (ebus),
      .ebusBusy       (busy),
      .ebusDone       (done),
      .ebusTimeout    (timeout),
      .ebusParityErr  (parity_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      int n_dem;
      int n_done;
      n_vec       = 0;
      n_err       = 0;
      rst_n       = 1'b0;
      req         = 1'b0;
      write       = 1'b0;
      cs          = '0;
      f           = '0;
      edp_ebus    = '0;
      edp_driving = 1'b0;
      xfer        = 1'b0;
      data_in     = '0;
      parity_in   = 1'b0;

      // Reset state
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_demand", demand, 0);
      chk("rst_ebus", ebus, 0);
      chk("rst_cs", bus_cs, 0);
      chk("rst_timeout", timeout, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Read cycle: demand after three edges, capture on XFER
      req = 1'b1; write = 1'b0; cs = 7'h04; f = F_DATAI;
      tick();
      req = 1'b0;
      chk("rd_busy", busy, 1);
      chk("rd_cs", bus_cs, 7'h04);
      chk("rd_f", bus_f, 3);
      chk("rd_dem_e0", demand, 0);
      tick();
      chk("rd_dem_e1", demand, 0);
      tick();
      chk("rd_dem_e2", demand, 1);
      chk("rd_drive", drive_en, 0);
      tick(); tick(); tick();
      chk("rd_dem_wait", demand, 1);
      xfer = 1'b1; data_in = 36'h123456789; parity_in = 1'b0;
      tick();
      chk("rd_ebus", ebus, 36'h123456789);
      chk("rd_hold_dem", demand, 1);
      chk("rd_hold_done", done, 0);
      xfer = 1'b0; data_in = 36'h0;
      tick();
      chk("rd_done", done, 1);
      chk("rd_done_dem", demand, 0);
      chk("rd_done_cs", bus_cs, 7'h04);
      tick();
      chk("rd_done_clr", done, 0);
      chk("rd_idle", busy, 0);
      chk("rd_cs_clr", bus_cs, 0);
      chk("rd_f_clr", bus_f, 0);
      chk("rd_ebus_keep", ebus, 36'h123456789);

      // Write cycle with edp already driving
      edp_driving = 1'b1; edp_ebus = 36'h987654321;
      req = 1'b1; write = 1'b1; cs = 7'h10; f = F_DATAO;
      tick();
      req = 1'b0; edp_driving = 1'b0; edp_ebus = 36'hFFFFFFFFF;
      chk("wr_dout", data_out, 36'h987654321);
      chk("wr_drive_setup", drive_en, 1);
      tick(); tick();
      chk("wr_demand", demand, 1);
      chk("wr_drive_dem", drive_en, 1);
      xfer = 1'b1; data_in = 36'hFFFFFFFFF;
      tick();
      chk("wr_drive_hold", drive_en, 1);
      chk("wr_ebus_keep", ebus, 36'h123456789);
      xfer = 1'b0;
      tick();
      chk("wr_done", done, 1);
      chk("wr_drive_off", drive_en, 0);
      chk("wr_dout_keep", data_out, 36'h987654321);
      tick();

      // Write cycle waiting for edp, then DEMAND timeout
      req = 1'b1; write = 1'b1; cs = 7'h22; f = F_CONO;
      tick();
      req = 1'b0;
      tick(); tick();
      chk("wd_busy", busy, 1);
      chk("wd_drive", drive_en, 0);
      chk("wd_demand", demand, 0);
      edp_driving = 1'b1; edp_ebus = 36'h0ABCDEF01;
      tick();
      edp_driving = 1'b0;
      chk("wd_dout", data_out, 36'h0ABCDEF01);
      chk("wd_drive_on", drive_en, 1);
      tick(); tick();
      chk("to_dem_start", demand, 1);
      n_dem  = 1;
      n_done = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (done) n_done++;
         if (!demand) break;
         n_dem++;
      end
      chk("to_dem_cycles", n_dem, 255);
      chk("to_no_done", n_done, 0);
      chk("to_flag", timeout, 1);
      chk("to_drive_off", drive_en, 0);
      chk("to_idle", busy, 0);

      // Next request clears timeout; a req during DEMAND is ignored
      req = 1'b1; write = 1'b0; cs = 7'h01; f = F_CONI;
      tick();
      req = 1'b0;
      chk("to_clear", timeout, 0);
      tick(); tick();
      chk("ig_demand", demand, 1);
      req = 1'b1; cs = 7'h7F; f = 3'd7;
      tick();
      req = 1'b0;
      chk("ig_cs", bus_cs, 7'h01);
      chk("ig_f", bus_f, 1);
      xfer = 1'b1; data_in = 36'h555555555;
      tick();
      xfer = 1'b0;
      tick();
      chk("ig_done", done, 1);
      n_done = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done) n_done++;
      end
      chk("ig_extra_done", n_done, 0);
      chk("ig_busy", busy, 0);
      chk("ig_ebus", ebus, 36'h555555555);

      // Parity: data 1 with parity 1 gives even total
      req = 1'b1; write = 1'b0; cs = 7'h05; f = F_DATAI;
      tick();
      req = 1'b0;
      tick(); tick();
      xfer = 1'b1; data_in = 36'h000000001; parity_in = 1'b1;
      tick();
      xfer = 1'b0; parity_in = 1'b0;
      chk("par_ebus", ebus, 36'h000000001);
`ifdef EBUS_PARITY_EN
      chk("par_err", parity_err, 1);
`else
      chk("par_err", parity_err, 0);
`endif
      tick();
      chk("par_done", done, 1);
      tick();

      // Asynchronous reset in the middle of a write DEMAND
      edp_driving = 1'b1; edp_ebus = 36'h111111111;
      req = 1'b1; write = 1'b1; cs = 7'h33; f = F_DATAO;
      tick();
      req = 1'b0; edp_driving = 1'b0;
      tick(); tick();
      chk("ar_demand", demand, 1);
      chk("ar_drive", drive_en, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_demand_off", demand, 0);
      chk("ar_drive_off", drive_en, 0);
      chk("ar_busy_off", busy, 0);
      chk("ar_ebus", ebus, 0);
      chk("ar_dout", data_out, 0);
      chk("ar_cs", bus_cs, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("ar_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ebus_xfer.md
Name: ebus_xfer

Overview:
- EBUS cycle sequencer for the EBOX I/O path. It runs DATAI/DATAO/CONI/CONO-style transfers between the EBOX and EBUS devices.
- Downstream of edp: it consumes EDP_EBUS and EDPdrivingEBUS for write cycles.
- Upstream of edp: it produces the registered EBUS word that edp reads on read cycles.
- Sequences controller-select/function setup, DEMAND/XFER handshake and timeout.

Parameters:
- SETUP_CYC, 2, eboxClk cycles CS/F held stable before DEMAND asserts (min 1).
- TIMEOUT_CYC, 255, max cycles in DEMAND waiting for XFER before abort (min 1).
- CNT_W, 8, counter width; must satisfy 2**CNT_W > max(SETUP_CYC, TIMEOUT_CYC).

Ports:
- eboxClk  in  1  EBOX clock, all state on posedge.
- eboxReset_n  in  1  asynchronous active-low reset.
- CON_ebusReq  in  1  start pulse; sampled only in IDLE.
- CON_ebusWrite  in  1  1 = EBOX drives data (DATAO/CONO); 0 = device drives (DATAI/CONI).
- CON_ebusCS  in  [0:6]  controller select.
- CON_ebusF  in  [0:2]  EBUS function.
- EDP_EBUS  in  [0:35]  write data from edp.
- EDPdrivingEBUS  in  1  edp has valid data on EDP_EBUS.
- EBUS_xfer  in  1  device transfer acknowledge.
- EBUS_dataIn  in  [0:35]  device read data.
- EBUS_parityIn  in  1  device odd parity (used only with EBUS_PARITY_EN).
- EBUS_cs  out  [0:6]  registered CS to bus.
- EBUS_f  out  [0:2]  registered function to bus.
- EBUS_demand  out  1  DEMAND.
- EBUS_dataOut  out  [0:35]  registered write data.
- EBUS_driveEn  out  1  EBOX drives EBUS data lines.
- EBUS  out  [0:35]  captured read word to edp.
- ebusBusy  out  1  not IDLE.
- ebusDone  out  1  one-cycle completion pulse.
- ebusTimeout  out  1  sticky timeout flag.
- ebusParityErr  out  1  sticky parity error flag (tied 0 without macro).

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0, including EBUS, flags and counter.
- States: IDLE, SETUP, WAITD, DEMAND, HOLD, DONE.
- IDLE:
  - CON_ebusReq=1 latches CS, F and write into EBUS_cs/EBUS_f/dir, clears ebusTimeout and ebusParityErr, loads counter=SETUP_CYC-1.
  - Next state is WAITD if write and !EDPdrivingEBUS, else SETUP.
- WAITD: on EDPdrivingEBUS=1, latch EDP_EBUS into EBUS_dataOut and go to SETUP. No timeout in WAITD.
- SETUP:
  - On SETUP entry for a write cycle, latch EBUS_dataOut (if not already latched) and assert EBUS_driveEn.
  - Decrement counter; at 0 go to DEMAND, load counter=TIMEOUT_CYC-1.
  - Exact latency from req to EBUS_demand high: SETUP_CYC+1 cycles (no WAITD).
- DEMAND:
  - EBUS_demand=1.
  - EBUS_xfer=1: on a read, EBUS<=EBUS_dataIn the same edge; go to HOLD.
  - Else counter==0: set ebusTimeout, drop demand/driveEn, go to IDLE. No ebusDone on timeout.
  - Else decrement.
  - XFER sampled 1 on the same edge the counter reaches 0: XFER wins.
- HOLD: keep demand until EBUS_xfer=0, then drop demand and driveEn and go to DONE. XFER held indefinitely keeps HOLD (no timeout).
- DONE: ebusDone=1 for one cycle, clear EBUS_cs/EBUS_f to 0, go to IDLE.
- CON_ebusReq outside IDLE is ignored, not queued.
- EBUS retains its last read value until the next read capture or reset.
- ebusBusy = (state != IDLE).

Optional Feature:
- EBUS_PARITY_EN defined:
  - On read capture, check XOR(EBUS_dataIn, EBUS_parityIn)==1 (odd).
  - Failure sets sticky ebusParityErr; data is still captured and the cycle completes normally.
- Undefined: ebusParityErr tied 0 and EBUS_parityIn unused.

Decomposition:
- Shared package ebus_pkg holds:
  - state enum encoding;
  - EBUS function code constants (F_CONO=0, F_CONI=1, F_DATAO=2, F_DATAI=3, F_PIserved=4);
  - the 36-bit word width constant.
- One sub-module: ebus_timer, a loadable down-counter with zero flag, used for both the SETUP and DEMAND counts.

Test Plan:
- Read (defaults): req with write=0, CS=7'h04, F=3 -> demand high 3 cycles after req; device XFER with dataIn=36'h123456789 after 4 cycles -> EBUS=36'h123456789; drop XFER -> ebusDone pulse; busy low next cycle.
- Write: EDPdrivingEBUS=1, EDP_EBUS=36'h987654321, req write=1 -> EBUS_dataOut=36'h987654321 with driveEn high from SETUP through HOLD; EBUS unchanged.
- Timeout (TIMEOUT_CYC=255): no XFER -> demand held exactly 255 cycles, then ebusTimeout=1, no ebusDone; next req clears the flag.
- Req pulses during busy: second req at DEMAND ignored -> exactly one ebusDone, CS/F keep the first values.
- Reset mid-DEMAND: eboxReset_n low asynchronously -> demand, driveEn and busy drop immediately with no clock; EBUS reads 0.
- With EBUS_PARITY_EN: dataIn=36'h000000001, parityIn=1 (even total) -> ebusParityErr=1, EBUS still 36'h000000001, ebusDone pulses.
